// File: rtl/sha256_pkg.sv
// Definitions shared by the SHA-256 compression core and its message padder:
// round constants, initial hash words, round functions and padder block geometry.
package sha256_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;

  localparam logic [31:0] H0_INITIAL = 32'h6a09e667;
  localparam logic [31:0] H1_INITIAL = 32'hbb67ae85;
  localparam logic [31:0] H2_INITIAL = 32'h3c6ef372;
  localparam logic [31:0] H3_INITIAL = 32'ha54ff53a;
  localparam logic [31:0] H4_INITIAL = 32'h510e527f;
  localparam logic [31:0] H5_INITIAL = 32'h9b05688c;
  localparam logic [31:0] H6_INITIAL = 32'h1f83d9ab;
  localparam logic [31:0] H7_INITIAL = 32'h5be0cd19;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Working variables of one compression round.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } stage_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEND,
    ST_EXTRA
  } pad_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Bit offset of byte idx inside a block; byte 0 is the most significant.
  function automatic int byte_lsb(input logic [5:0] idx);
    return (BLOCK_BYTES - 1 - int'(idx)) * 8;
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Message, block, digest and final-hash channels between the padder and its neighbours.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic                     msg_valid;
  logic [7:0]               msg_data;
  logic                     msg_last;
  logic                     msg_ready;

  logic                     blk_valid;
  logic [BLOCK_BYTES*8-1:0] blk_data;
  logic                     blk_new;
  logic                     blk_ready;

  logic                     dig_valid;
  logic [255:0]             dig_data;
  logic                     dig_ready;

  logic                     hash_valid;
  logic [255:0]             hash;
  logic                     hash_ready;

  modport slave (
    input  msg_valid, msg_data, msg_last, blk_ready, dig_valid, dig_data, hash_ready,
    output msg_ready, blk_valid, blk_data, blk_new, dig_ready, hash_valid, hash
  );

  modport master (
    output msg_valid, msg_data, msg_last, blk_ready, dig_valid, dig_data, hash_ready,
    input  msg_ready, blk_valid, blk_data, blk_new, dig_ready, hash_valid, hash
  );

endinterface

// File: rtl/sha256_padder.sv
// Byte-stream to 512-bit block padder for the SHA-256 core; forwards only the
// digest of each message's final block as the hash.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sha256_padder_if.slave bus
);

  localparam logic [5:0]       PTR_LAST = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0]       PTR_FIT  = 6'(LEN_OFFSET - 1);
  localparam logic [LEN_W-4:0] CNT_ONE  = 1;

  pad_state_t r_state;
  pad_state_t w_state_nxt;

  logic [5:0]               r_ptr;
  logic [LEN_W-4:0]         r_cnt;
  logic [63:0]              r_len;
  logic                     r_first;
  logic                     r_final;
  logic                     r_extra;
  logic                     r_extra_pl;
  logic                     r_final_sent;
  logic [BLOCK_BYTES*8-1:0] r_buf;
  logic                     r_hash_valid;
  logic [255:0]             r_hash;

  logic                     w_msg_ready;
  logic                     w_blk_valid;
  logic                     w_blk_new;
  logic                     w_accept;
  logic                     w_blk_hs;
  logic                     w_dig_hs;
  logic                     w_fits;
  logic [LEN_W-4:0]         w_cnt_inc;
  logic [LEN_W-1:0]         w_len_bits;
  logic [63:0]              w_len64;
  logic [BLOCK_BYTES*8-1:0] w_fill_buf;
  logic [BLOCK_BYTES*8-1:0] w_extra_buf;

  assign w_accept   = bus.msg_valid && w_msg_ready;
  assign w_blk_hs   = w_blk_valid && bus.blk_ready;
  assign w_dig_hs   = bus.dig_valid && !r_hash_valid;
  assign w_fits     = r_ptr < PTR_FIT;
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_len_bits = {w_cnt_inc, 3'b000};
  assign w_len64    = 64'(w_len_bits);

  // Overflow block: zeros plus length, led by 0x80 when the message filled the last block exactly.
  assign w_extra_buf = {(r_extra_pl ? 8'h80 : 8'h00), {(BLOCK_BYTES*8-72){1'b0}}, r_len};

  always_comb begin
    w_fill_buf = r_buf;
    w_fill_buf[byte_lsb(r_ptr) +: 8] = bus.msg_data;
    if (bus.msg_last && (r_ptr != PTR_LAST)) begin
      w_fill_buf[byte_lsb(r_ptr + 6'd1) +: 8] = 8'h80;
    end
    if (bus.msg_last && w_fits) begin
      w_fill_buf[63:0] = w_len64;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_msg_ready = 1'b0;
    w_blk_valid = 1'b0;
    w_blk_new   = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        w_msg_ready = 1'b1;
        if (bus.msg_valid && (bus.msg_last || (r_ptr == PTR_LAST))) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_blk_valid = 1'b1;
        w_blk_new   = r_first;
        if (bus.blk_ready) begin
          w_state_nxt = r_extra ? ST_EXTRA : ST_FILL;
        end
      end
      ST_EXTRA: begin
        w_blk_valid = 1'b1;
        if (bus.blk_ready) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_first      <= 1'b1;
      r_final      <= 1'b0;
      r_extra      <= 1'b0;
      r_extra_pl   <= 1'b0;
      r_final_sent <= 1'b0;
      r_buf        <= '0;
    end else begin
      if (w_dig_hs && r_final_sent) begin
        r_final_sent <= 1'b0;
      end
      unique case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_buf <= w_fill_buf;
            if (bus.msg_last) begin
              r_ptr      <= '0;
              r_cnt      <= '0;
              r_len      <= w_len64;
              r_final    <= w_fits;
              r_extra    <= !w_fits;
              r_extra_pl <= (r_ptr == PTR_LAST);
            end else begin
              r_ptr   <= r_ptr + 6'd1;
              r_cnt   <= w_cnt_inc;
              r_final <= 1'b0;
              r_extra <= 1'b0;
            end
          end
        end
        ST_SEND: begin
          if (w_blk_hs) begin
            r_first <= r_final;
            r_extra <= 1'b0;
            r_buf   <= r_extra ? w_extra_buf : '0;
            if (r_final) begin
              r_final_sent <= 1'b1;
            end
          end
        end
        ST_EXTRA: begin
          if (w_blk_hs) begin
            r_first      <= 1'b1;
            r_final_sent <= 1'b1;
            r_buf        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Intermediate digests are swallowed; only the one following a final block is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hash_valid <= 1'b0;
      r_hash       <= '0;
    end else begin
      if (r_hash_valid && bus.hash_ready) begin
        r_hash_valid <= 1'b0;
      end
      if (w_dig_hs && r_final_sent) begin
        r_hash       <= bus.dig_data;
        r_hash_valid <= 1'b1;
      end
    end
  end

  assign bus.msg_ready  = w_msg_ready;
  assign bus.blk_valid  = w_blk_valid;
  assign bus.blk_data   = r_buf;
  assign bus.blk_new    = w_blk_new;
  assign bus.dig_ready  = !r_hash_valid;
  assign bus.hash_valid = r_hash_valid;
  assign bus.hash       = r_hash;

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Message-side initiator for the sha256 compression core.
- Accepts a byte stream and applies FIPS 180-4 padding: 0x80, zero fill, then a 64-bit big-endian bit length.
- Emits 512-bit blocks on the core's in_valid/in/new_hash/in_ready interface, with new_hash set on the first block of each message.
- Consumes the core's per-block digests, discards the intermediate ones, and presents only the final 256-bit hash.

Parameters:
- LEN_W, 64: width of the bit-length counter. Legal range 8..64. Upper bits of the 64-bit length field are zero-filled.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- msg_valid  in  1  byte valid
- msg_data  in  8  message byte, first byte first
- msg_last  in  1  marks the final byte of a message (minimum message length 1 byte)
- msg_ready  out  1  byte accepted when msg_valid && msg_ready
- blk_valid  out  1  to core in_valid
- blk_data  out  512  to core in; message byte 0 of the block sits at [511:504]
- blk_new  out  1  to core new_hash; high on the first block of a message
- blk_ready  in  1  from core in_ready
- dig_valid  in  1  from core out_valid
- dig_data  in  256  from core out
- dig_ready  out  1  to core out_ready
- hash_valid  out  1  final digest valid
- hash  out  256  final digest, H0 in [255:224]
- hash_ready  in  1  consumer accept

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous and active-high.
- Reset values:
  - state FILL, ptr=0, byte count 0, first=1, final_sent=0.
  - blk_valid=0, hash_valid=0, hash=0, blk_data=0.
  - msg_ready=1 and dig_ready=1 from the first cycle after reset.
  - Reset mid-message or mid-block drops all buffered data and the hash; no partial block is emitted afterwards.
- Handshakes:
  - All transfers are valid/ready.
  - blk_valid, blk_data and blk_new stay stable until blk_ready is sampled high.
  - hash and hash_valid stay stable until hash_ready.
- FILL (msg_ready=1):
  - An accepted byte is written at byte position ptr; ptr increments; byte count increments modulo 2^LEN_W/8.
  - Non-last byte at ptr=63 → block complete, go to SEND.
  - Last byte at position p:
    - p≤54: 0x80 at p+1, zeros through byte 55, length (count×8) in bytes 56..63; mark the block final; go to SEND.
    - 55≤p≤62: 0x80 at p+1, zeros to byte 63; go to SEND with extra_pending=1 and extra block type ZL (zeros + length).
    - p=63: go to SEND with extra_pending=1 and extra block type PL (0x80 at byte 0, zeros, length).
- SEND (msg_ready=0, blk_valid=1):
  - blk_valid rises in the cycle after the completing byte is accepted (1-cycle latency).
  - On handshake: clear first; if the block is final, set final_sent.
  - Next state: extra_pending → EXTRA, otherwise FILL with ptr=0 and the buffer cleared.
- EXTRA:
  - The extra block is built in the cycle after SEND's handshake.
  - blk_valid=1, blk_new=0; it is always final.
  - On handshake: set final_sent, go to FILL.
- Digest side (independent of message filling):
  - dig_ready = !hash_valid.
  - A digest accepted while final_sent=0 is discarded (intermediate block).
  - A digest accepted while final_sent=1 is latched into hash, sets hash_valid and clears final_sent.
- Next message:
  - FILL may accept the next message's bytes while the hash is still held.
  - The next final digest stalls via dig_ready=0 until hash_ready.
- The length counter wraps modulo 2^LEN_W silently.
- blk_new is derived from `first`, which is set again after the final block's handshake.

Decomposition:
- Shared package sha256_pkg:
  - stage struct, H*_INITIAL constants, K table, S0/S1/s0/s1 functions (moved out of the core).
  - New constants BLOCK_BYTES=64 and LEN_OFFSET=56.
- No sub-module: the padder is a single module.
- A later top level instantiates sha256_padder together with the core.

Test Plan:
- "abc" (61 62 63, last on 63):
  - Single block, blk_new=1.
  - blk_data = 61626380, zeros, 00000018.
  - hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Two blocks; the second is zeros + 0x1C0.
  - hash = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - The first digest is discarded; hash_valid pulses exactly once.
- 55 bytes of 0x00 → single block with 0x80 at byte 55 and length 0x1B8.
- 64 bytes of 0x00:
  - Two blocks; the second starts 0x80 and ends with 0x200.
  - blk_new is 1 only on the first block.
- Backpressure:
  - Hold blk_ready=0 for 10 cycles → blk_data stable, msg_ready=0.
  - Hold hash_ready=0 across a second "abc" → second digest stalls (dig_ready=0), then both hashes appear in order.
- Reset for one cycle after 30 bytes of a message, then send "abc":
  - No block from the aborted message appears.
  - The "abc" digest is correct, with blk_new=1.
